// File: rtl/svc_delay_rv.sv
// svc_delay_rv: ready/valid delay pipeline with bubble collapse.
// Each beat leaves no earlier than CYCLES clocks after acceptance.
module svc_delay_rv #(
  parameter int CYCLES = 3,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic [CYCLES-1:0] v;
  logic [WIDTH-1:0]  d [CYCLES];
  logic [CYCLES-1:0] adv;

  // advance chain: a stage moves if empty or the stage ahead moves
  always_comb begin
    adv = '0;
    adv[CYCLES-1] = !v[CYCLES-1] | m_ready;
    for (int i = CYCLES - 2; i >= 0; i--) begin
      adv[i] = !v[i] | adv[i+1];
    end
  end

  // stage registers: load from the stage behind when advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < CYCLES; i++) begin
        d[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= s_valid;
        d[0] <= s_data;
      end
      for (int i = 1; i < CYCLES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign s_ready = adv[0];
  assign m_valid = v[CYCLES-1];
  assign m_data  = d[CYCLES-1];

endmodule
